// File: rtl/mem_access_pkg.sv
// mem_access_pkg
// Shared types for the MEM stage: memory op codes, FSM state encoding and
// small helpers that classify an op and give its byte count.
package mem_access_pkg;

    localparam int MEM_OP_WIDTH = 4;
    localparam int BYTE_WIDTH   = 8;

    typedef enum logic [MEM_OP_WIDTH-1:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LH   = 4'd2,
        MEM_LW   = 4'd3,
        MEM_LBU  = 4'd4,
        MEM_LHU  = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } mem_op_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    function automatic logic is_load(mem_op_t op);
        return op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
    endfunction

    function automatic logic is_store(mem_op_t op);
        return op inside {MEM_SB, MEM_SH, MEM_SW};
    endfunction

    // Number of bytes moved over the 8-bit RAM port; 0 for non-memory codes.
    function automatic logic [2:0] byte_count(mem_op_t op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: return 3'd1;
            MEM_LH, MEM_LHU, MEM_SH: return 3'd2;
            MEM_LW, MEM_SW:          return 3'd4;
            default:                 return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_load_extend.sv
// mem_access_load_extend
// Combinational sign/zero extension of the assembled load word.
// Ports:
//   op     - latched memory op of the completed load
//   word   - little-endian assembled bytes (unused upper bytes are zero)
//   result - write-back value for mem_wb
module mem_access_load_extend
    import mem_access_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  mem_op_t         op,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] result
);

    always_comb begin
        result = word;
        case (op)
            MEM_LB:  result = {{(XLEN-8){word[7]}}, word[7:0]};
            MEM_LH:  result = {{(XLEN-16){word[15]}}, word[15:0]};
            MEM_LBU: result = {{(XLEN-8){1'b0}}, word[7:0]};
            MEM_LHU: result = {{(XLEN-16){1'b0}}, word[15:0]};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// mem_access
// MEM stage of the RV32I pipeline. ALU results pass straight through; loads
// and stores are executed one byte per granted cycle over a shared 8-bit RAM
// port, holding the pipeline through stall_req until the write-back value is
// ready.
// Ports:
//   clk_in, rst_n_in        - clock, asynchronous active-low reset
//   rdy_in                  - global ready, 0 freezes the block
//   stall_in                - stall bus, bit 4 holds the MEM stage
//   rd_address_in/rd_data_in, mem_op_in, mem_addr_in, mem_wdata_in - from ex_mem
//   rd_address, rd_data     - to mem_wb
//   stall_req               - hold stages 0-4
//   mem_req, mem_gnt_in     - arbiter handshake (grant in the same cycle)
//   ram_addr, ram_wr, ram_dout, ram_din - byte RAM port (read data one cycle late)
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int XLEN       = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  rdy_in,
    input  logic [5:0]            stall_in,
    input  logic [4:0]            rd_address_in,
    input  logic [XLEN-1:0]       rd_data_in,
    input  logic [3:0]            mem_op_in,
    input  logic [ADDR_WIDTH-1:0] mem_addr_in,
    input  logic [XLEN-1:0]       mem_wdata_in,
    output logic [4:0]            rd_address,
    output logic [XLEN-1:0]       rd_data,
    output logic                  stall_req,
    output logic                  mem_req,
    input  logic                  mem_gnt_in,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_wr,
    output logic [7:0]            ram_dout,
    input  logic [7:0]            ram_din
);

    state_t                state_q, state_d;
    mem_op_t               op_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [XLEN-1:0]       wdata_q;
    logic [4:0]            rd_q;
    logic [2:0]            cnt_q;
    logic                  cap_pending_q;
    logic [XLEN-1:0]       asm_q;
    logic [XLEN-1:0]       ext_data;

    mem_op_t               op_in;
    logic                  start;
    logic                  issue;
    logic                  last_byte;
    logic [1:0]            cap_idx;
    logic                  stall_unused;

    assign op_in        = mem_op_t'(mem_op_in);
    assign start        = (state_q == ST_IDLE) && (is_load(op_in) || is_store(op_in));
    assign issue        = (state_q == ST_ACCESS) && mem_gnt_in && rdy_in;
    assign last_byte    = issue && ((cnt_q + 3'd1) == byte_count(op_q));
    // The byte being captured is the one issued in the previous granted cycle.
    assign cap_idx      = cnt_q[1:0] - 2'd1;
    assign stall_unused = ^{stall_in[5], stall_in[3:0]};

    mem_access_load_extend #(.XLEN(XLEN)) u_load_extend (
        .op     (op_q),
        .word   (asm_q),
        .result (ext_data)
    );

    // State and datapath registers; nothing moves while rdy_in is low.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q       <= ST_IDLE;
            op_q          <= MEM_NONE;
            base_q        <= '0;
            wdata_q       <= '0;
            rd_q          <= '0;
            cnt_q         <= '0;
            cap_pending_q <= 1'b0;
            asm_q         <= '0;
        end else if (rdy_in) begin
            state_q       <= state_d;
            cap_pending_q <= issue && is_load(op_q);
            if (start) begin
                op_q    <= op_in;
                base_q  <= mem_addr_in;
                wdata_q <= mem_wdata_in;
                rd_q    <= rd_address_in;
                cnt_q   <= '0;
                asm_q   <= '0;
            end
            if (issue) begin
                cnt_q <= cnt_q + 3'd1;
            end
            if (cap_pending_q) begin
                asm_q[{cap_idx, 3'b000} +: 8] <= ram_din;
            end
        end
    end

    // Next state and all outputs. Outputs are forced to zero while reset is
    // asserted so the pass-through path cannot leak ex_mem values.
    always_comb begin
        state_d    = state_q;
        stall_req  = 1'b0;
        mem_req    = 1'b0;
        ram_wr     = 1'b0;
        ram_addr   = '0;
        ram_dout   = '0;
        rd_address = '0;
        rd_data    = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    stall_req = 1'b1;
                    state_d   = ST_ACCESS;
                end else begin
                    rd_address = rd_address_in;
                    rd_data    = rd_data_in;
                end
            end
            ST_ACCESS: begin
                stall_req = 1'b1;
                mem_req   = rdy_in;
                ram_addr  = base_q + ADDR_WIDTH'(cnt_q);
                if (issue) begin
                    ram_wr = is_store(op_q);
                    if (is_store(op_q)) begin
                        ram_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                    end
                    if (last_byte) begin
                        state_d = is_store(op_q) ? ST_DONE : ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                stall_req = 1'b1;
                state_d   = ST_DONE;
            end
            ST_DONE: begin
                if (is_load(op_q)) begin
                    rd_address = rd_q;
                    rd_data    = ext_data;
                end
                // Holding here while MEM is stalled keeps a store from replaying.
                if (!stall_in[4]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (!rst_n_in) begin
            stall_req  = 1'b0;
            mem_req    = 1'b0;
            ram_wr     = 1'b0;
            ram_addr   = '0;
            ram_dout   = '0;
            rd_address = '0;
            rd_data    = '0;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access
// Self-checking bench for mem_access: a byte RAM with one-cycle read latency,
// a shadow memory used by the reference model, directed vector table,
// hand-written corner sequences and randomized ops with grant/ready gaps.
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk_in;
    logic        rst_n_in;
    logic        rdy_in;
    logic [5:0]  stall_in;
    logic [4:0]  rd_address_in;
    logic [31:0] rd_data_in;
    logic [3:0]  mem_op_in;
    logic [31:0] mem_addr_in;
    logic [31:0] mem_wdata_in;
    logic [4:0]  rd_address;
    logic [31:0] rd_data;
    logic        stall_req;
    logic        mem_req;
    logic        mem_gnt_in;
    logic [31:0] ram_addr;
    logic        ram_wr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;

    int checks = 0;
    int errors = 0;
    int wrViol = 0;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic [7:0] ram    [logic [31:0]];
    logic [7:0] shadow [logic [31:0]];
    wr_t        wlog[$];

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] preAddr;
        logic [31:0] preWord;
        int          preBytes;
        logic [4:0]  expRd;
        logic [31:0] expData;
        int          expStall;
    } vec_t;

    vec_t vecs[$];

    mem_access #(.ADDR_WIDTH(32), .XLEN(32)) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .rdy_in        (rdy_in),
        .stall_in      (stall_in),
        .rd_address_in (rd_address_in),
        .rd_data_in    (rd_data_in),
        .mem_op_in     (mem_op_in),
        .mem_addr_in   (mem_addr_in),
        .mem_wdata_in  (mem_wdata_in),
        .rd_address    (rd_address),
        .rd_data       (rd_data),
        .stall_req     (stall_req),
        .mem_req       (mem_req),
        .mem_gnt_in    (mem_gnt_in),
        .ram_addr      (ram_addr),
        .ram_wr        (ram_wr),
        .ram_dout      (ram_dout),
        .ram_din       (ram_din)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Byte RAM behind the arbiter: writes land at the edge, reads return one cycle later.
    always @(posedge clk_in) begin
        if (ram_wr && !(mem_req && mem_gnt_in)) wrViol++;
        if (mem_req && mem_gnt_in) begin
            if (ram_wr) begin
                ram[ram_addr] = ram_dout;
                wlog.push_back('{ram_addr, ram_dout});
            end else begin
                ram_din <= ram.exists(ram_addr) ? ram[ram_addr] : 8'h00;
            end
        end
    end

    initial begin
        #2ms;
        $display("[TB] FAIL global timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    function automatic int nBytes(input logic [3:0] op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: return 1;
            MEM_LH, MEM_LHU, MEM_SH: return 2;
            MEM_LW, MEM_SW:          return 4;
            default:                 return 0;
        endcase
    endfunction

    function automatic bit isLoadOp(input logic [3:0] op);
        return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
               (op == MEM_LBU) || (op == MEM_LHU);
    endfunction

    function automatic logic [7:0] shadowByte(input logic [31:0] a);
        return shadow.exists(a) ? shadow[a] : 8'h00;
    endfunction

    // Reference load: little-endian value from the shadow memory, then signed
    // reinterpretation for LB/LH done with plain arithmetic.
    function automatic logic [31:0] modelLoad(input logic [3:0] op, input logic [31:0] addr);
        longint v;
        logic [31:0] a;
        v = 0;
        for (int k = 0; k < nBytes(op); k++) begin
            a = addr + 32'(k);
            v = v + (longint'(shadowByte(a)) << (8 * k));
        end
        if (op == MEM_LB && v >= 128)   v = v - 256;
        if (op == MEM_LH && v >= 32768) v = v - 65536;
        return v[31:0];
    endfunction

    task automatic preload(input logic [31:0] addr, input logic [31:0] word, input int cnt);
        logic [31:0] a;
        logic [31:0] w;
        w = word;
        for (int k = 0; k < cnt; k++) begin
            a = addr + 32'(k);
            ram[a]    = w[7:0];
            shadow[a] = w[7:0];
            w = w >> 8;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual 0x%08h required 0x%08h", name, actual, expected);
        end
    endtask

    task automatic scrambleInputs();
        mem_op_in     = 4'($urandom);
        mem_addr_in   = $urandom;
        mem_wdata_in  = $urandom;
        rd_address_in = 5'($urandom);
        rd_data_in    = $urandom;
    endtask

    // Runs one memory op starting #1 after a rising edge. The model tracks
    // abstract progress: 1 cycle to accept, one granted cycle per byte, one
    // extra cycle for load data, each needing rdy_in; then the result cycle.
    task automatic runOp(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] rd, input int gntPct, input int rdyPct,
                         input bit altGnt, input int rdyLowAt, input int holdCycles,
                         output int obsStall, output logic [4:0] obsRd, output logic [31:0] obsData);
        int n, pTotal, p, cyc, stallErr, reqErr, doneErr, writeErr;
        bit isLd, rdyV, gntV, expReq;
        logic [31:0] expData, a, w;
        logic [4:0] expRd;
        n        = nBytes(op);
        isLd     = isLoadOp(op);
        pTotal   = 1 + n + (isLd ? 1 : 0);
        expData  = isLd ? modelLoad(op, addr) : 32'h0;
        expRd    = isLd ? rd : 5'd0;
        p = 0; cyc = 0; stallErr = 0; reqErr = 0; doneErr = 0; writeErr = 0;
        obsStall = 0; obsRd = '0; obsData = '0;
        wlog.delete();
        mem_op_in = op; mem_addr_in = addr; mem_wdata_in = wdata;
        rd_address_in = rd; rd_data_in = $urandom; stall_in = 6'b0;
        while (p < pTotal && cyc < 100) begin
            if (p >= 1) scrambleInputs();
            rdyV = (cyc == rdyLowAt) ? 1'b0 : ($urandom_range(99) < rdyPct);
            gntV = altGnt ? (cyc % 2 == 1) : ($urandom_range(99) < gntPct);
            rdy_in = rdyV;
            mem_gnt_in = gntV;
            @(negedge clk_in);
            if (stall_req !== 1'b1) stallErr++; else obsStall++;
            expReq = rdyV && (p >= 1) && (p <= n);
            if (mem_req !== expReq) reqErr++;
            if (rdyV && (((p >= 1) && (p <= n)) ? gntV : 1'b1)) p++;
            @(posedge clk_in); #1;
            cyc++;
        end
        if (p < pTotal) begin
            checks++; errors++;
            $display("[TB] FAIL op timeout: op %0d stuck after %0d cycles", op, cyc);
        end
        for (int h = 0; h <= holdCycles; h++) begin
            scrambleInputs();
            rdy_in = 1'b1;
            mem_gnt_in = 1'($urandom);
            stall_in = (h < holdCycles) ? 6'b010000 : 6'b000000;
            @(negedge clk_in);
            if (stall_req !== 1'b0 || mem_req !== 1'b0 || rd_address !== expRd || rd_data !== expData)
                doneErr++;
            obsRd = rd_address;
            obsData = rd_data;
            @(posedge clk_in); #1;
        end
        stall_in = 6'b0;
        checkOutput("stall pattern", 32'(stallErr), 32'd0);
        checkOutput("mem_req pattern", 32'(reqErr), 32'd0);
        checkOutput("done outputs", 32'(doneErr), 32'd0);
        checkOutput("write count", 32'(wlog.size()), isLd ? 32'd0 : 32'(n));
        if (!isLd) begin
            w = wdata;
            for (int k = 0; k < n; k++) begin
                a = addr + 32'(k);
                if (k < wlog.size()) begin
                    if (wlog[k].addr !== a || wlog[k].data !== w[7:0]) writeErr++;
                end
                shadow[a] = w[7:0];
                w = w >> 8;
            end
            checkOutput("write bytes", 32'(writeErr), 32'd0);
        end
    endtask

    task automatic passThrough(input logic [4:0] rd, input logic [31:0] data);
        mem_op_in = MEM_NONE; rd_address_in = rd; rd_data_in = data;
        mem_addr_in = $urandom; rdy_in = 1'b1; mem_gnt_in = 1'b0; stall_in = 6'b0;
        @(negedge clk_in);
        checkOutput("pass rd_address", 32'(rd_address), 32'(rd));
        checkOutput("pass rd_data", rd_data, data);
        checkOutput("pass stall_req", 32'(stall_req), 32'd0);
        checkOutput("pass mem_req", 32'(mem_req), 32'd0);
        @(posedge clk_in); #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        int obsStall;
        logic [4:0] obsRd;
        logic [31:0] obsData;
        preload(v.preAddr, v.preWord, v.preBytes);
        if (v.op == MEM_NONE) begin
            passThrough(v.rd, v.alu);
        end else begin
            runOp(v.op, v.addr, v.wdata, v.rd, 100, 100, 1'b0, -1, 0, obsStall, obsRd, obsData);
            checkOutput("vec stall cycles", 32'(obsStall), 32'(v.expStall));
            checkOutput("vec rd_address", 32'(obsRd), 32'(v.expRd));
            checkOutput("vec rd_data", obsData, v.expData);
            mem_op_in = MEM_NONE;
        end
    endtask

    initial begin
        int obsStall;
        logic [4:0] obsRd;
        logic [31:0] obsData;
        logic [3:0] op;
        logic [31:0] addr;

        rst_n_in = 1'b0; rdy_in = 1'b1; stall_in = 6'b0; mem_gnt_in = 1'b1;
        rd_address_in = 5'd5; rd_data_in = 32'h12345678; mem_op_in = MEM_NONE;
        mem_addr_in = '0; mem_wdata_in = '0;
        #3;
        checkOutput("reset rd_address", 32'(rd_address), 32'd0);
        checkOutput("reset rd_data", rd_data, 32'd0);
        checkOutput("reset stall_req", 32'(stall_req), 32'd0);
        checkOutput("reset mem_req", 32'(mem_req), 32'd0);
        checkOutput("reset ram_wr", 32'(ram_wr), 32'd0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(posedge clk_in); #1;

        vecs.push_back('{MEM_NONE, 32'h0, 32'h0, 5'd5, 32'h12345678, 32'h0, 32'h0, 0, 5'd5, 32'h12345678, 0});
        vecs.push_back('{MEM_NONE, 32'h0, 32'h0, 5'd31, 32'hFFFFFFFF, 32'h0, 32'h0, 0, 5'd31, 32'hFFFFFFFF, 0});
        vecs.push_back('{MEM_SW, 32'h100, 32'hDEADBEEF, 5'd3, 32'h55, 32'h0, 32'h0, 0, 5'd0, 32'h0, 5});
        vecs.push_back('{MEM_LB, 32'h203, 32'h0, 5'd7, 32'h0, 32'h203, 32'h80, 1, 5'd7, 32'hFFFFFF80, 3});
        vecs.push_back('{MEM_LBU, 32'h203, 32'h0, 5'd7, 32'h0, 32'h0, 32'h0, 0, 5'd7, 32'h00000080, 3});
        vecs.push_back('{MEM_LH, 32'hFFFFFFFF, 32'h0, 5'd9, 32'h0, 32'hFFFFFFFF, 32'h1234, 2, 5'd9, 32'h00001234, 4});
        vecs.push_back('{MEM_LHU, 32'h401, 32'h0, 5'd10, 32'h0, 32'h401, 32'h9001, 2, 5'd10, 32'h00009001, 4});
        vecs.push_back('{MEM_LH, 32'h401, 32'h0, 5'd10, 32'h0, 32'h0, 32'h0, 0, 5'd10, 32'hFFFF9001, 4});
        vecs.push_back('{MEM_LW, 32'h302, 32'h0, 5'd11, 32'h0, 32'h302, 32'h44332211, 4, 5'd11, 32'h44332211, 6});
        vecs.push_back('{MEM_SB, 32'h500, 32'h123456AB, 5'd12, 32'h0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 2});
        vecs.push_back('{MEM_SH, 32'hFFFFFFFF, 32'h0000CDEF, 5'd13, 32'h0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 3});
        vecs.push_back('{MEM_LHU, 32'hFFFFFFFF, 32'h0, 5'd14, 32'h0, 32'h0, 32'h0, 0, 5'd14, 32'h0000CDEF, 4});
        vecs.push_back('{MEM_LB, 32'hFFFFFFFF, 32'h0, 5'd1, 32'h0, 32'h0, 32'h0, 0, 5'd1, 32'hFFFFFFEF, 3});

        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

        $display("[TB] LW with alternating grant and one unready cycle");
        preload(32'h800, 32'hCAFEBABE, 4);
        runOp(MEM_LW, 32'h800, 32'h0, 5'd14, 0, 100, 1'b1, 3, 0, obsStall, obsRd, obsData);
        checkOutput("gap stall cycles", 32'(obsStall), 32'd11);
        checkOutput("gap rd_data", obsData, 32'hCAFEBABE);
        mem_op_in = MEM_NONE;

        $display("[TB] SW held in result state by stall_in[4]");
        runOp(MEM_SW, 32'h900, 32'h0BADF00D, 5'd15, 100, 100, 1'b0, -1, 3, obsStall, obsRd, obsData);
        checkOutput("hold stall cycles", 32'(obsStall), 32'd5);
        passThrough(5'd6, 32'h600DCAFE);

        $display("[TB] reset in the middle of a SW");
        wlog.delete();
        mem_op_in = MEM_SW; mem_addr_in = 32'hA00; mem_wdata_in = 32'h11223344;
        rd_address_in = 5'd16; rdy_in = 1'b1; mem_gnt_in = 1'b1; stall_in = 6'b0;
        @(posedge clk_in); #1;
        @(posedge clk_in); #1;
        @(posedge clk_in); #1;
        rst_n_in = 1'b0;
        #1;
        checkOutput("abort stall_req", 32'(stall_req), 32'd0);
        checkOutput("abort mem_req", 32'(mem_req), 32'd0);
        checkOutput("abort ram_wr", 32'(ram_wr), 32'd0);
        checkOutput("abort ram_addr", ram_addr, 32'd0);
        checkOutput("abort ram_dout", 32'(ram_dout), 32'd0);
        checkOutput("abort rd_address", 32'(rd_address), 32'd0);
        checkOutput("abort rd_data", rd_data, 32'd0);
        mem_op_in = MEM_NONE;
        @(posedge clk_in);
        @(negedge clk_in);
        checkOutput("abort write count", 32'(wlog.size()), 32'd2);
        checkOutput("abort byte2 untouched", 32'(ram.exists(32'hA02)), 32'd0);
        rst_n_in = 1'b1;
        @(posedge clk_in); #1;
        passThrough(5'd4, 32'hCAFEF00D);

        $display("[TB] randomized ops");
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(1, 8));
            if ($urandom_range(0, 3) == 0) addr = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
            else addr = 32'h700 + 32'($urandom_range(0, 31));
            runOp(op, addr, $urandom, 5'($urandom), 60, 85, 1'b0, -1, $urandom_range(0, 2),
                  obsStall, obsRd, obsData);
            passThrough(5'($urandom), $urandom);
        end

        checkOutput("ram_wr without grant", 32'(wrViol), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
